wb_mprj_xbar: RTL

//  Parametrised Wishbone B4-classic 1-to-N decoder that replaces the single hard-wired user project

---
 rtl/wb_mprj_xbar_if.sv | 39 +++
 rtl/wb_mprj_xbar.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wb_mprj_xbar_if.sv
// Bus bundle for wb_mprj_xbar: the management-SoC Wishbone slave port,
// the shared/one-hot downstream slave signals and the sticky error flag.
interface wb_mprj_xbar_if #(
   parameter int unsigned N_SLAVES  = 4,
   parameter int unsigned SLOT_BITS = 16
);
   logic                    wbs_cyc_i;
   logic                    wbs_stb_i;
   logic                    wbs_we_i;
   logic [3:0]              wbs_sel_i;
   logic [31:0]             wbs_adr_i;
   logic [31:0]             wbs_dat_i;
   logic                    wbs_ack_o;
   logic [31:0]             wbs_dat_o;
   logic [N_SLAVES-1:0]     s_cyc_o;
   logic [N_SLAVES-1:0]     s_stb_o;
   logic                    s_we_o;
   logic [3:0]              s_sel_o;
   logic [SLOT_BITS-1:0]    s_adr_o;
   logic [31:0]             s_dat_o;
   logic [N_SLAVES-1:0]     s_ack_i;
   logic [32*N_SLAVES-1:0]  s_dat_i;
   logic                    err_o;

   // The crossbar itself sits on the slave modport.
   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  s_ack_i, s_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output s_ack_i, s_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_o
   );
endinterface

// File: rtl/wb_mprj_xbar.sv
// Wishbone B4-classic 1-to-N decoder for the user project area: one registered
// transaction in flight, error completion on unmapped/timeout, status register in slot N_SLAVES.
module wb_mprj_xbar #(
   parameter int unsigned N_SLAVES  = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned SLOT_BITS = 16,
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
   input logic           wb_clk_i,
   input logic           wb_rst_i,
   wb_mprj_xbar_if.slave bus
);
   localparam int unsigned IDX_W  = $clog2(N_SLAVES + 1);
   localparam int unsigned PFX_LO = SLOT_BITS + IDX_W;

   typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [31:0] status_word(input logic [15:0] cnt, input logic e,
                                               input logic [7:0] slot);
      return {cnt, 7'b0, e, slot};
   endfunction

   state_t               state;
   logic [IDX_W-1:0]     idx_q;
   logic [N_SLAVES-1:0]  oh_q;
   logic                 we_q;
   logic [3:0]           sel_q;
   logic [SLOT_BITS-1:0] adr_q;
   logic [31:0]          wdat_q;
   logic [31:0]          rdat_q;
   logic                 ack_q;
   logic [15:0]          tmo_cnt;
   logic [15:0]          err_cnt;
   logic                 err_q;
   logic [7:0]           last_err_slot;

   logic [IDX_W-1:0]     dec_idx;
   logic                 pfx_hit;
   logic                 dec_slave;
   logic                 dec_status;
   logic [N_SLAVES-1:0]  dec_oh;
   logic                 ack_hit;
   logic [31:0]          rd_mux;

   // Selection in REQ is taken from the one-hot strobe register, so stray acks are masked.
   always_comb begin
      dec_idx    = bus.wbs_adr_i[SLOT_BITS +: IDX_W];
      pfx_hit    = (bus.wbs_adr_i[31:PFX_LO] == BASE_ADDR[31:PFX_LO]);
      dec_slave  = pfx_hit && (dec_idx < IDX_W'(N_SLAVES));
      dec_status = pfx_hit && (dec_idx == IDX_W'(N_SLAVES));
      dec_oh     = '0;
      rd_mux     = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         dec_oh[k] = (dec_idx == IDX_W'(k));
         rd_mux    = rd_mux | (bus.s_dat_i[32*k +: 32] & {32{oh_q[k]}});
      end
      ack_hit = |(bus.s_ack_i & oh_q);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= IDLE;
         idx_q         <= '0;
         oh_q          <= '0;
         we_q          <= 1'b0;
         sel_q         <= '0;
         adr_q         <= '0;
         wdat_q        <= '0;
         rdat_q        <= '0;
         ack_q         <= 1'b0;
         tmo_cnt       <= '0;
         err_cnt       <= '0;
         err_q         <= 1'b0;
         last_err_slot <= 8'hFF;
      end else begin
         ack_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                  if (dec_slave) begin
                     state   <= REQ;
                     idx_q   <= dec_idx;
                     oh_q    <= dec_oh;
                     we_q    <= bus.wbs_we_i;
                     sel_q   <= bus.wbs_sel_i;
                     adr_q   <= bus.wbs_adr_i[SLOT_BITS-1:0];
                     wdat_q  <= bus.wbs_dat_i;
                     tmo_cnt <= '0;
                  end else if (dec_status) begin
                     state <= ACK;
                     ack_q <= 1'b1;
                     if (bus.wbs_we_i) begin
                        err_cnt       <= '0;
                        err_q         <= 1'b0;
                        last_err_slot <= 8'hFF;
                        rdat_q        <= '0;
                     end else begin
                        rdat_q <= status_word(err_cnt, err_q, last_err_slot);
                     end
                  end else begin
                     state         <= ACK;
                     ack_q         <= 1'b1;
                     rdat_q        <= ERR_DATA;
                     err_q         <= 1'b1;
                     err_cnt       <= sat_inc16(err_cnt);
                     last_err_slot <= 8'hFF;
                  end
               end
            end
            REQ: begin
               if (!bus.wbs_cyc_i) begin
                  state <= IDLE;
                  oh_q  <= '0;
               end else if (ack_hit) begin
                  state  <= ACK;
                  ack_q  <= 1'b1;
                  oh_q   <= '0;
                  rdat_q <= we_q ? 32'h0 : rd_mux;
               end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                  state         <= ACK;
                  ack_q         <= 1'b1;
                  oh_q          <= '0;
                  rdat_q        <= ERR_DATA;
                  err_q         <= 1'b1;
                  err_cnt       <= sat_inc16(err_cnt);
                  last_err_slot <= 8'(idx_q);
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.wbs_ack_o = ack_q;
   assign bus.wbs_dat_o = rdat_q;
   assign bus.s_cyc_o   = oh_q;
   assign bus.s_stb_o   = oh_q;
   assign bus.s_we_o    = we_q;
   assign bus.s_sel_o   = sel_q;
   assign bus.s_adr_o   = adr_q;
   assign bus.s_dat_o   = wdat_q;
   assign bus.err_o     = err_q;
endmodule
